mpu9250_read_sequencer: RTL
===========================

// Module: mpu9250_read_sequencer
// PURPOSE
//   Frame sequencer for the single-register I2C read engine on the MPU9250 path.
//   On a periodic tick or a START pulse, issues NUM_REGS back-to-back single-byte reads at BASE_REG..BASE_REG+NUM_REGS-1.
//   Streams each byte out with its index, then closes the frame with a done/error pulse.
//   Sits between the I2C read engine (GO/BUSY/ACK_err/READ_DATA) and the sensor-data consumer.
// PARAMETERS
//   BASE_REG   8'h3B  first register of frame (ACCEL_XOUT_H)
//   NUM_REGS   14     registers per frame (accel 6, temp 2, gyro 6), range 1..16
//   PERIOD     50000  CLK cycles between periodic triggers, >=2
//   TIMEOUT    1024   max CLK cycles in either wait state before abort
//   MAX_RETRY  2      retries per register on ACK error (MPU_SEQ_RETRY_EN only)
// PORTS
//   CLK          in   1  system clock; all logic on posedge
//   reset        in   1  synchronous, active-high
//   EN           in   1  periodic-trigger enable
//   START        in   1  one-shot frame trigger, level sampled per cycle
//   DEV_ADDR     in   7  I2C device address (7'h68 typical)
//   I2C_GO       out  1  read request to engine
//   I2C_ADDR     out  7  device address to engine
//   I2C_REG_ADDR out  8  register address to engine
//   I2C_BUSY     in   1  engine busy, already synchronous to CLK
//   I2C_ACK_ERR  in   1  engine ACK error, valid when BUSY low
//   I2C_DATA     in   8  engine read data, valid when BUSY low
//   BYTE_VALID   out  1  1-cycle strobe: BYTE_IDX/BYTE_DATA valid
//   BYTE_IDX     out  4  register index within frame, 0..NUM_REGS-1
//   BYTE_DATA    out  8  byte read
//   FRAME_DONE   out  1  1-cycle strobe at frame end, good or aborted
//   FRAME_ERR    out  1  qualified by FRAME_DONE: 1 = frame aborted
//   SEQ_BUSY     out  1  high in every state except IDLE
//   OVERRUN      out  1  sticky: a trigger was dropped; cleared only by reset
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; idx, period, timeout and retry counters 0.
//     I2C_GO drops in the same cycle even if the engine is mid-transaction.
//   Trigger = START | (EN & period tick). Tick fires when counter == PERIOD-1; counter then wraps to 0.
//     Counter holds at 0 while EN=0. START and tick in the same cycle produce one trigger.
//   Trigger acceptance:
//     IDLE with I2C_BUSY=0: accept -> ISSUE, idx=0.
//     Any other state, or IDLE with I2C_BUSY=1 (e.g. after a mid-transfer reset): drop trigger, set OVERRUN.
//   States:
//     IDLE.
//     ISSUE: I2C_GO=1, I2C_ADDR=DEV_ADDR, I2C_REG_ADDR=BASE_REG+idx (8-bit wrap). Next cycle -> WAIT_BUSY.
//     WAIT_BUSY: hold I2C_GO=1 until I2C_BUSY=1, then GO=0 -> WAIT_DONE.
//     WAIT_DONE: wait for I2C_BUSY=0, then sample I2C_ACK_ERR and I2C_DATA.
//       ACK ok: BYTE_VALID=1 for one cycle with idx/data. If idx==NUM_REGS-1 -> DONE, else idx+1 -> ISSUE.
//       ACK error: -> ERR (or retry, see CONFIGURATION).
//     DONE: FRAME_DONE=1, FRAME_ERR=0 for one cycle -> IDLE.
//     ERR: FRAME_DONE=1, FRAME_ERR=1 for one cycle, I2C_GO=0 -> IDLE. BYTE_IDX holds the failing index.
//   Timeout: counter clears on entry to each wait state; reaching TIMEOUT -> ERR. Timeouts are never retried.
//   GO is always low before the engine returns to idle, so no spurious re-issue.
//   Latency: trigger -> I2C_GO = 1 cycle. BUSY fall -> BYTE_VALID = 1 cycle. Last BYTE_VALID -> FRAME_DONE = 1 cycle.
// CONFIGURATION
//   MPU_SEQ_RETRY_EN defined: on ACK error, if retry count < MAX_RETRY, increment it and -> ISSUE with the same idx;
//     otherwise -> ERR. Retry count clears whenever idx advances.
//   Undefined: the first ACK error -> ERR. MAX_RETRY is unused.
// STRUCTURE
//   mpu_seq_pkg: state encoding constants; MPU9250 constants (ADDR_AD0_LOW=7'h68, ACCEL_XOUT_H=8'h3B, WHO_AM_I=8'h75).
//   Sub-module mpu_seq_period_timer: PERIOD counter, EN gating, 1-cycle tick output.
// TESTING
//   EN=0, START pulse, engine model returns 8'hA0+i -> 14 BYTE_VALID, idx 0..13, data A0..AD; FRAME_DONE=1, FRAME_ERR=0.
//   PERIOD=100, EN=1, fast engine -> FRAME_DONE every 100 cycles; OVERRUN stays 0.
//   Engine ACK error on idx 3, retry undefined -> bytes 0..2 only; FRAME_DONE & FRAME_ERR, BYTE_IDX=3.
//   MPU_SEQ_RETRY_EN, ACK error twice on idx 5 -> 14 bytes, FRAME_ERR=0; three errors -> abort at idx 5.
//   Engine never raises BUSY -> GO high for TIMEOUT cycles, then FRAME_ERR=1, GO=0.
//   START during a frame -> OVERRUN=1, frame unaffected; reset mid-frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mpu_seq_pkg.sv
// mpu_seq_pkg: shared constants and types for the MPU9250 read sequencer.
//   - FSM state encodings (3-bit, legacy-compatible localparams)
//   - MPU9250 register/address constants
//   - i2c_req_t: request bundle presented to the I2C read engine
//   - reg_at(): register address of frame index idx (8-bit wrap)
package mpu_seq_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;
  localparam logic [2:0] S_ERR       = 3'd5;

  localparam logic [6:0] ADDR_AD0_LOW = 7'h68;
  localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
  localparam logic [7:0] WHO_AM_I     = 8'h75;

  typedef struct packed {
    logic       go;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
  } i2c_req_t;

  function automatic logic [7:0] reg_at(input logic [7:0] base, input logic [3:0] idx);
    return base + {4'd0, idx};
  endfunction

endpackage

// File: rtl/mpu_seq_period_timer.sv
// mpu_seq_period_timer: free-running PERIOD counter for periodic frame triggers.
//   CLK   in  system clock
//   reset in  synchronous, active-high
//   EN    in  count enable; counter held at 0 while low
//   TICK  out 1-cycle strobe when counter == PERIOD-1 (counter wraps to 0)
module mpu_seq_period_timer #(
  parameter int PERIOD = 50000
) (
  input  logic CLK,
  input  logic reset,
  input  logic EN,
  output logic TICK
);
  localparam int CW = $clog2(PERIOD);

  logic [CW-1:0] cnt;

  assign TICK = EN && (cnt == CW'(PERIOD - 1));

  always_ff @(posedge CLK) begin
    if (reset || !EN) cnt <= '0;
    else if (TICK)    cnt <= '0;
    else              cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/mpu9250_read_sequencer.sv
// mpu9250_read_sequencer: frame sequencer in front of a single-register I2C read engine.
// On START or a periodic tick, reads NUM_REGS bytes at BASE_REG.., streams each byte with
// its index, then closes the frame with FRAME_DONE (FRAME_ERR=1 if aborted).
//   CLK, reset            clock, synchronous active-high reset
//   EN, START             periodic enable, one-shot trigger
//   DEV_ADDR              I2C device address
//   I2C_GO/ADDR/REG_ADDR  request to engine
//   I2C_BUSY/ACK_ERR/DATA engine status and read data
//   BYTE_VALID/IDX/DATA   byte stream to consumer
//   FRAME_DONE/ERR        end-of-frame strobe and abort flag
//   SEQ_BUSY              not idle
//   OVERRUN               sticky dropped-trigger flag
// Optional: define MPU_SEQ_RETRY_EN to retry a register up to MAX_RETRY times on ACK error.
module mpu9250_read_sequencer
  import mpu_seq_pkg::*;
#(
  parameter logic [7:0] BASE_REG  = ACCEL_XOUT_H,
  parameter int         NUM_REGS  = 14,
  parameter int         PERIOD    = 50000,
  parameter int         TIMEOUT   = 1024,
  parameter int         MAX_RETRY = 2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       EN,
  input  logic       START,
  input  logic [6:0] DEV_ADDR,
  output logic       I2C_GO,
  output logic [6:0] I2C_ADDR,
  output logic [7:0] I2C_REG_ADDR,
  input  logic       I2C_BUSY,
  input  logic       I2C_ACK_ERR,
  input  logic [7:0] I2C_DATA,
  output logic       BYTE_VALID,
  output logic [3:0] BYTE_IDX,
  output logic [7:0] BYTE_DATA,
  output logic       FRAME_DONE,
  output logic       FRAME_ERR,
  output logic       SEQ_BUSY,
  output logic       OVERRUN
);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    state;
  logic [3:0]    idx;
  logic [TW-1:0] tcnt;
  i2c_req_t      req;
  logic          tick, trigger, accept, last, tmo;

`ifdef MPU_SEQ_RETRY_EN
  logic [3:0] retry_cnt;
`else
  // Retry limit has no effect when retries are compiled out.
  logic unused_max_retry;
  assign unused_max_retry = ^MAX_RETRY;
`endif

  mpu_seq_period_timer #(.PERIOD(PERIOD)) u_timer (
    .CLK   (CLK),
    .reset (reset),
    .EN    (EN),
    .TICK  (tick)
  );

  assign trigger = START | tick;
  // Engine still busy in IDLE means a transaction survived a reset; don't collide with it.
  assign accept  = (state == S_IDLE) && !I2C_BUSY;
  assign last    = (idx == 4'(NUM_REGS - 1));
  assign tmo     = (tcnt == TW'(TIMEOUT - 1));

  assign I2C_GO       = req.go;
  assign I2C_ADDR     = req.dev_addr;
  assign I2C_REG_ADDR = req.reg_addr;
  assign SEQ_BUSY     = (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      tcnt       <= '0;
      req        <= '0;
      BYTE_VALID <= 1'b0;
      BYTE_IDX   <= '0;
      BYTE_DATA  <= '0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
      OVERRUN    <= 1'b0;
`ifdef MPU_SEQ_RETRY_EN
      retry_cnt  <= '0;
`endif
    end else begin
      BYTE_VALID <= 1'b0;
      FRAME_DONE <= 1'b0;
      FRAME_ERR  <= 1'b0;
      if (trigger && !accept) OVERRUN <= 1'b1;

      case (state)
        S_IDLE: if (trigger && accept) begin
          state        <= S_ISSUE;
          idx          <= '0;
          req.go       <= 1'b1;
          req.dev_addr <= DEV_ADDR;
          req.reg_addr <= reg_at(BASE_REG, 4'd0);
`ifdef MPU_SEQ_RETRY_EN
          retry_cnt    <= '0;
`endif
        end

        S_ISSUE: begin
          state <= S_WAIT_BUSY;
          tcnt  <= '0;
        end

        // GO held until the engine acknowledges with BUSY
        S_WAIT_BUSY: begin
          if (I2C_BUSY) begin
            req.go <= 1'b0;
            state  <= S_WAIT_DONE;
            tcnt   <= '0;
          end else if (tmo) begin
            req.go   <= 1'b0;
            BYTE_IDX <= idx;
            state    <= S_ERR;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        S_WAIT_DONE: begin
          if (!I2C_BUSY) begin
            if (!I2C_ACK_ERR) begin
              BYTE_VALID <= 1'b1;
              BYTE_IDX   <= idx;
              BYTE_DATA  <= I2C_DATA;
              if (last) begin
                state <= S_DONE;
              end else begin
                idx          <= idx + 4'd1;
                req.go       <= 1'b1;
                req.reg_addr <= reg_at(BASE_REG, idx + 4'd1);
                state        <= S_ISSUE;
`ifdef MPU_SEQ_RETRY_EN
                retry_cnt    <= '0;
`endif
              end
            end else begin
`ifdef MPU_SEQ_RETRY_EN
              if (retry_cnt < 4'(MAX_RETRY)) begin
                retry_cnt <= retry_cnt + 4'd1;
                req.go    <= 1'b1;
                state     <= S_ISSUE;
              end else begin
                BYTE_IDX <= idx;
                state    <= S_ERR;
              end
`else
              BYTE_IDX <= idx;
              state    <= S_ERR;
`endif
            end
          end else if (tmo) begin
            BYTE_IDX <= idx;
            state    <= S_ERR;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        S_DONE: begin
          FRAME_DONE <= 1'b1;
          state      <= S_IDLE;
        end

        S_ERR: begin
          FRAME_DONE <= 1'b1;
          FRAME_ERR  <= 1'b1;
          req.go     <= 1'b0;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
